imem_boot_loader: RTL
=====================

// Module: imem_boot_loader
// PURPOSE
//  Debug-unit controller that loads a program into the instruction memory before execution.
//  Assembles a serial byte stream (UART rx strobe) into 32-bit instructions, big-endian.
//  Writes each instruction to consecutive word addresses, starting at 0.
//  Holds the CPU while it drives the imem write port; otherwise passes the PC address through.
// PARAMETERS
//  DATA_W     32             instruction width (fixed at 4 bytes)
//  DEPTH      32             instruction memory depth in words
//  ADDR_W     5              log2(DEPTH)
//  HALT_WORD  32'hFFFF_FFFF  end-of-program marker; it is written, then the load ends
// PORTS
//  clk          in   1       system clock; all logic on posedge
//  rst          in   1       synchronous, active-high reset
//  start        in   1       1-cycle pulse: begin a load (accepted in IDLE or DONE only)
//  rx_data      in   8       received byte
//  rx_valid     in   1       1-cycle strobe: rx_data valid this cycle
//  pc_addr      in   32      fetch address from the PC stage
//  imem_addr    out  32      address to imem: pc_addr when not loading, else {0,wr_ptr}
//  imem_wr      out  1       imem write enable (maps to wr_instruction)
//  imem_wdata   out  32      instruction to write (maps to data_instruction)
//  cpu_hold     out  1       stall PC/pipeline while 1
//  done         out  1       load finished; sticky until next start or rst
//  overflow     out  1       load ended because memory filled without HALT_WORD
//  word_count   out  ADDR_W+1  words written in the current/last load
// BEHAVIOUR
//  Reset: state=IDLE; imem_wr=0, imem_wdata=0, cpu_hold=0, done=0, overflow=0, word_count=0,
//   byte_cnt=0, wr_ptr=0. All outputs are registered except the imem_addr mux (IDLE/DONE: =pc_addr).
//  Register on posedge, so outputs are stable at the imem's negedge sampling point.
//  IDLE: start -> RECV; clear byte_cnt, wr_ptr, word_count, done, overflow.
//  RECV: cpu_hold=1. On rx_valid: asm <= {asm[23:0],rx_data}, byte_cnt++.
//   On the 4th byte (byte_cnt==3), load the completed word into imem_wdata, set byte_cnt=0, -> WRITE.
//  WRITE (exactly 1 cycle): imem_wr=1, imem_addr=wr_ptr, cpu_hold=1; word_count++.
//   if imem_wdata==HALT_WORD        -> DONE (done=1)
//   elif wr_ptr==DEPTH-1             -> DONE (done=1, overflow=1); wr_ptr does not wrap
//   else wr_ptr++                    -> RECV
//   rx_valid in WRITE is accepted as byte 0 of the next word (asm is free); ignored if going to DONE.
//  DONE: cpu_hold=0, imem_wr=0, imem_addr=pc_addr; rx_valid ignored; start -> RECV (restart at addr 0).
//  Latency: 4th byte strobe in cycle N -> imem_wr=1 in cycle N+1 -> next word can start in N+1.
//  start in RECV/WRITE: ignored. start together with rx_valid in IDLE: the byte is dropped.
//  rst mid-load: -> IDLE at the next edge; partial word discarded; words already written remain in imem.
//  Word 0 == HALT_WORD: the halt word is written at addr 0, word_count=1, done=1.
// STRUCTURE
//  Shared package (dbg_pkg): state encoding {IDLE,RECV,WRITE,DONE}, HALT_WORD, and the DEPTH/ADDR_W defaults.
//  Sub-module byte_assembler: shift register plus 2-bit byte counter.
//   Inputs: clk, rst, clr, rx_data, rx_valid. Outputs: word[31:0], word_ready pulse.
//  Top level: FSM, wr_ptr/word_count counters, and the imem_addr mux.
// TESTING
//  1. Reset, then start; send bytes 00 22 18 20, FF FF FF FF.
//     -> write 0x00221820 @0 and 0xFFFFFFFF @1; done=1, word_count=2, overflow=0.
//  2. Send 32 non-halt words (value = index).
//     -> 32 writes at addr 0..31, done=1, overflow=1, no write at 32; later rx ignored.
//  3. Back-to-back bytes, a rx_valid every cycle.
//     -> one imem_wr per 4 bytes; the byte arriving in the WRITE cycle is not lost; data matches.
//  4. Assert rst after 2 bytes of word 3.
//     -> IDLE next cycle, cpu_hold=0, imem_addr=pc_addr, words 0..2 intact.
//     New start reloads from addr 0.
//  5. Pulse start during RECV.
//     -> ignored (no counter clear). Pulse start in DONE -> new load; done/overflow cleared.
//  6. In IDLE, pc_addr sweeps 0..31 with rx_valid toggling.
//     -> imem_addr==pc_addr every cycle, imem_wr never asserted.

Source files
------------

// File: rtl/dbg_pkg.sv
// Shared definitions for the debug-unit instruction-memory boot loader:
// controller states, end-of-program marker and default memory geometry.
package dbg_pkg;

  localparam int          DEF_DATA_W    = 32;
  localparam int          DEF_DEPTH     = 32;
  localparam int          DEF_ADDR_W    = $clog2(DEF_DEPTH);
  localparam logic [31:0] DEF_HALT_WORD = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE,
    RECV,
    WRITE,
    DONE
  } state_t;

endpackage

// File: rtl/imem_boot_loader_byte_assembler.sv
// Big-endian byte-to-word assembler: shifts received bytes in and flags the
// cycle in which the fourth byte completes a 32-bit word.
module byte_assembler (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [31:0] word,
  output logic        word_ready
);

  logic [23:0] asm_q;
  logic [1:0]  byte_cnt;

  // The completed word is presented in the same cycle as its last byte so the
  // controller can register it without an extra stage.
  assign word       = {asm_q, rx_data};
  assign word_ready = rx_valid && !clr && (byte_cnt == 2'd3);

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      asm_q    <= '0;
      byte_cnt <= '0;
    end else if (clr) begin
      byte_cnt <= '0;
    end else if (rx_valid) begin
      asm_q    <= word[23:0];
      byte_cnt <= byte_cnt + 2'd1;
    end
  end

endmodule

// File: rtl/imem_boot_loader.sv
// Boot loader: streams bytes from the UART into consecutive imem words,
// holding the CPU while loading and passing the PC address through otherwise.
module imem_boot_loader
  import dbg_pkg::*;
#(
  parameter int          DATA_W    = DEF_DATA_W,
  parameter int          DEPTH     = DEF_DEPTH,
  parameter int          ADDR_W    = DEF_ADDR_W,
  parameter logic [31:0] HALT_WORD = DEF_HALT_WORD
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  input  logic [31:0]       pc_addr,
  output logic [31:0]       imem_addr,
  output logic              imem_wr,
  output logic [DATA_W-1:0] imem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              overflow,
  output logic [ADDR_W:0]   word_count
);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] wr_ptr;
  logic [31:0]       word;
  logic              word_ready;
  logic              is_halt, at_end, load_start, byte_en;

  assign is_halt    = (imem_wdata == HALT_WORD);
  assign at_end     = (wr_ptr == ADDR_W'(DEPTH - 1));
  assign load_start = start && (state == IDLE || state == DONE);
  // A byte arriving during WRITE starts the next word, unless the load ends here.
  assign byte_en    = rx_valid &&
                      (state == RECV || (state == WRITE && !is_halt && !at_end));

  assign imem_addr  = (state == RECV || state == WRITE) ? 32'(wr_ptr) : pc_addr;

  byte_assembler u_asm (
    .clk        (clk),
    .rst        (rst),
    .clr        (load_start),
    .rx_data    (rx_data),
    .rx_valid   (byte_en),
    .word       (word),
    .word_ready (word_ready)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // NOTE: next_state gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE, DONE: if (start)      state_nxt = RECV;
      RECV:       if (word_ready) state_nxt = WRITE;
      WRITE:      state_nxt = (is_halt || at_end) ? DONE : RECV;
      default:    state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      imem_wr    <= 1'b0;
      imem_wdata <= '0;
      cpu_hold   <= 1'b0;
      done       <= 1'b0;
      overflow   <= 1'b0;
      word_count <= '0;
      wr_ptr     <= '0;
    end else begin
      imem_wr  <= (state_nxt == WRITE);
      cpu_hold <= (state_nxt == RECV || state_nxt == WRITE);
      if (word_ready) imem_wdata <= DATA_W'(word);
      if (load_start) begin
        wr_ptr     <= '0;
        word_count <= '0;
        done       <= 1'b0;
        overflow   <= 1'b0;
      end
      if (state == WRITE) begin
        word_count <= word_count + 1'b1;
        if (is_halt) begin
          done <= 1'b1;
        end else if (at_end) begin
          done     <= 1'b1;
          overflow <= 1'b1;
        end else begin
          wr_ptr <= wr_ptr + 1'b1;
        end
      end
    end
  end

endmodule
